// File: rtl/rle_frame_writer.sv
// rle_frame_writer
//   Expands a run-length-encoded 1-bit frame stream into single-pixel writes
//   for the frame BRAM write port, in raster order.
//
// Ports
//   clk_write     write-side clock (shared with the BRAM write port)
//   rst_n         asynchronous active-low reset
//   start         one-cycle pulse, begins a new frame at (0,0) when idle
//   in_data       token: [7] colour, [6:0] run length minus one
//   in_valid      token valid
//   in_ready      token accepted when in_valid && in_ready (combinational)
//   we            BRAM write enable
//   addr_write_x  column of the pixel being written
//   addr_write_y  row of the pixel being written
//   data_in       pixel value being written
//   busy          high from start acceptance until frame_done
//   frame_done    one-cycle pulse after the final pixel write
//   overrun       sticky: the stream supplied more pixels than one frame
module rle_frame_writer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDRW  = $clog2(WIDTH)
) (
    input  logic             clk_write,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             we,
    output logic [ADDRW-1:0] addr_write_x,
    output logic [ADDRW-1:0] addr_write_y,
    output logic             data_in,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    localparam logic [ADDRW-1:0] X_LAST = ADDRW'(WIDTH - 1);
    localparam logic [ADDRW-1:0] Y_LAST = ADDRW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [ADDRW-1:0] cur_x;
    logic [ADDRW-1:0] cur_y;
    logic [7:0]       rem;
    logic             colour;
    logic             emit;
    logic             last;
    logic             accept;

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A new token may be taken while the final pixel of the current run is
    // being written, so runs chain without a gap; never while the frame's
    // last pixel is going out, since nothing could consume it.
    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        last     = (cur_x == X_LAST) && (cur_y == Y_LAST);
        in_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = ACTIVE;
            end
            ACTIVE: begin
                emit     = (rem != 8'd0);
                in_ready = (rem == 8'd0) || ((rem == 8'd1) && !last);
                if (emit && last) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            cur_x        <= '0;
            cur_y        <= '0;
            rem          <= '0;
            colour       <= 1'b0;
            we           <= 1'b0;
            addr_write_x <= '0;
            addr_write_y <= '0;
            data_in      <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cur_x   <= '0;
                        cur_y   <= '0;
                        rem     <= '0;
                        overrun <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (emit) begin
                        we           <= 1'b1;
                        addr_write_x <= cur_x;
                        addr_write_y <= cur_y;
                        data_in      <= colour;
                        if (cur_x == X_LAST) begin
                            cur_x <= '0;
                            cur_y <= last ? '0 : cur_y + ADDRW'(1);
                        end else begin
                            cur_x <= cur_x + ADDRW'(1);
                        end
                    end
                    if (accept) begin
                        colour <= in_data[7];
                        rem    <= {1'b0, in_data[6:0]} + 8'd1;
                    end else if (emit && last) begin
                        // Frame is full: anything left in the run is dropped.
                        rem <= '0;
                        if (rem > 8'd1) overrun <= 1'b1;
                    end else if (emit) begin
                        rem <= rem - 8'd1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    if (in_valid) overrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_frame_writer.sv
module tb_rle_frame_writer;

    typedef struct {
        int x;
        int y;
        bit d;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A: full-size frame
    logic       a_rst_n, a_start, a_valid, a_ready, a_we, a_d, a_busy, a_fd, a_ovr;
    logic [7:0] a_data;
    logic [9:0] a_x, a_y;

    // Instance B: tiny 8x2 frame
    logic       b_rst_n, b_start, b_valid, b_ready, b_we, b_d, b_busy, b_fd, b_ovr;
    logic [7:0] b_data;
    logic [2:0] b_x, b_y;

    rle_frame_writer u_a (
        .clk_write(clk), .rst_n(a_rst_n), .start(a_start), .in_data(a_data),
        .in_valid(a_valid), .in_ready(a_ready), .we(a_we), .addr_write_x(a_x),
        .addr_write_y(a_y), .data_in(a_d), .busy(a_busy), .frame_done(a_fd),
        .overrun(a_ovr)
    );

    rle_frame_writer #(.WIDTH(8), .HEIGHT(2)) u_b (
        .clk_write(clk), .rst_n(b_rst_n), .start(b_start), .in_data(b_data),
        .in_valid(b_valid), .in_ready(b_ready), .we(b_we), .addr_write_x(b_x),
        .addr_write_y(b_y), .data_in(b_d), .busy(b_busy), .frame_done(b_fd),
        .overrun(b_ovr)
    );

    // Write / frame_done monitors, sampled on the falling edge
    wr_t a_wq[$];
    wr_t b_wq[$];
    int  b_fd_n = 0, b_fd_cyc = 0;
    bit  b_fd_busy = 1'b0;

    always @(negedge clk) begin
        if (a_we === 1'b1) a_wq.push_back('{int'(a_x), int'(a_y), a_d, cyc});
        if (b_we === 1'b1) b_wq.push_back('{int'(b_x), int'(b_y), b_d, cyc});
        if (b_fd === 1'b1) begin
            b_fd_n++;
            b_fd_cyc  = cyc;
            b_fd_busy = b_busy;
        end
    end

    // Reference model: expand the accepted tokens into raster-order pixels
    logic [7:0] tq[$];
    wr_t        eq[$];
    bit         exp_ovr;

    task automatic build_model(input int w, input int h);
        int p;
        logic [7:0] t;
        eq.delete();
        exp_ovr = 1'b0;
        p = 0;
        foreach (tq[i]) begin
            t = tq[i];
            for (int j = 0; j < int'(t[6:0]) + 1; j++) begin
                if (p < w * h) eq.push_back('{p % w, p / w, t[7], 0});
                else exp_ovr = 1'b1;
                p++;
            end
        end
    endtask

    // Stimulus helpers (all leave time at posedge + #1)
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_reset();
        a_rst_n = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_data = '0;
        idle(1);
        a_rst_n = 1'b1;
        idle(1);
        a_wq.delete();
    endtask

    task automatic b_reset();
        b_rst_n = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_data = '0;
        idle(1);
        b_rst_n = 1'b1;
        idle(1);
        b_wq.delete();
    endtask

    task automatic a_pulse_start();
        a_start = 1'b1;
        idle(1);
        a_start = 1'b0;
    endtask

    task automatic b_pulse_start();
        b_start = 1'b1;
        idle(1);
        b_start = 1'b0;
    endtask

    task automatic a_send(input logic [7:0] tok, output int acc_cyc);
        bit acc = 1'b0;
        int n = 0;
        a_data = tok; a_valid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = a_ready;
            @(posedge clk);
            #1;
            n++;
        end
        a_valid = 1'b0;
        acc_cyc = cyc;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL a_accept token=%h: in_ready never seen, required 1", tok);
        end
    endtask

    task automatic b_send(input logic [7:0] tok);
        bit acc = 1'b0;
        int n = 0;
        b_data = tok; b_valid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = b_ready;
            @(posedge clk);
            #1;
            n++;
        end
        b_valid = 1'b0;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL b_accept token=%h: in_ready never seen, required 1", tok);
        end
    endtask

    task automatic b_wait_done(input int budget);
        int n = 0;
        while (b_fd_n == 0 && n < budget) begin
            idle(1);
            n++;
        end
        vectors++;
        if (b_fd_n == 0) begin
            miscompares++;
            $display("FAIL b_frame_done_wait: no pulse within %0d cycles", budget);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        a_rst_n = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_data = '0;
        b_rst_n = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_data = '0;
        idle(2);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({a_we, a_x, a_y, a_d, a_busy, a_fd, a_ovr, a_ready} !== 27'd0) begin
                miscompares++;
                $display("FAIL a_reset_outputs[%0d]: got %b, required all zero", k,
                         {a_we, a_x, a_y, a_d, a_busy, a_fd, a_ovr, a_ready});
            end
            vectors++;
            if ({b_we, b_x, b_y, b_d, b_busy, b_fd, b_ovr, b_ready} !== 13'd0) begin
                miscompares++;
                $display("FAIL b_reset_outputs[%0d]: got %b, required all zero", k,
                         {b_we, b_x, b_y, b_d, b_busy, b_fd, b_ovr, b_ready});
            end
            a_rst_n = 1'b1;
            b_rst_n = 1'b1;
            idle(2);
        end
    endtask

    task automatic test_basic_run();
        int k;
        a_reset();
        a_pulse_start();
        vectors++;
        if (a_busy !== 1'b1 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_after_start: busy=%b in_ready=%b, required 1 1", a_busy, a_ready);
        end
        a_wq.delete();
        a_send(8'h83, k);
        idle(6);
        vectors++;
        if (a_wq.size() != 4) begin
            miscompares++;
            $display("FAIL basic_write_count: got %0d, required 4", a_wq.size());
        end
        for (int i = 0; i < a_wq.size() && i < 4; i++) begin
            vectors++;
            if (a_wq[i].x != i || a_wq[i].y != 0 || a_wq[i].d != 1'b1 || a_wq[i].cyc != k + 1 + i) begin
                miscompares++;
                $display("FAIL basic_write[%0d]: got x=%0d y=%0d d=%0d cyc=%0d, required x=%0d y=0 d=1 cyc=%0d",
                         i, a_wq[i].x, a_wq[i].y, a_wq[i].d, a_wq[i].cyc, i, k + 1 + i);
            end
        end
        vectors++;
        if (a_we !== 1'b0 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_after_run: we=%b in_ready=%b, required 0 1", a_we, a_ready);
        end
    endtask

    task automatic test_row_wrap();
        int k;
        int ex[4] = '{638, 639, 0, 1};
        int ey[4] = '{0, 0, 1, 1};
        a_reset();
        a_pulse_start();
        a_wq.delete();
        repeat (4) a_send(8'h7F, k);
        a_send(8'h7D, k);
        a_send(8'h03, k);
        idle(6);
        vectors++;
        if (a_wq.size() != 642) begin
            miscompares++;
            $display("FAIL wrap_write_count: got %0d, required 642", a_wq.size());
        end
        for (int i = 0; i < 4 && a_wq.size() >= 642; i++) begin
            vectors++;
            if (a_wq[638 + i].x != ex[i] || a_wq[638 + i].y != ey[i]) begin
                miscompares++;
                $display("FAIL wrap_write[%0d]: got (%0d,%0d), required (%0d,%0d)",
                         i, a_wq[638 + i].x, a_wq[638 + i].y, ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k0, k1, kx;
        bit ed[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        a_reset();
        a_pulse_start();
        a_wq.delete();
        a_send(8'h81, k0);
        a_send(8'h01, k1);
        vectors++;
        if (k1 != k0 + 2) begin
            miscompares++;
            $display("FAIL b2b_second_accept: got cycle %0d, required %0d", k1, k0 + 2);
        end
        idle(2);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            vectors++;
            if (a_we !== 1'b0 || a_x !== 10'd3 || a_y !== 10'd0) begin
                miscompares++;
                $display("FAIL b2b_stall[%0d]: we=%b x=%0d y=%0d, required 0 3 0", i, a_we, a_x, a_y);
            end
        end
        vectors++;
        if (a_wq.size() != 4) begin
            miscompares++;
            $display("FAIL b2b_write_count: got %0d, required 4", a_wq.size());
        end
        for (int i = 0; i < a_wq.size() && i < 4; i++) begin
            vectors++;
            if (a_wq[i].x != i || a_wq[i].d != ed[i] || a_wq[i].cyc != k0 + 1 + i) begin
                miscompares++;
                $display("FAIL b2b_write[%0d]: got x=%0d d=%0d cyc=%0d, required x=%0d d=%0d cyc=%0d",
                         i, a_wq[i].x, a_wq[i].d, a_wq[i].cyc, i, ed[i], k0 + 1 + i);
            end
        end
        // start while active must not disturb the cursor
        a_pulse_start();
        a_send(8'h80, kx);
        idle(3);
        vectors++;
        if (a_wq.size() != 5 || a_wq[a_wq.size() - 1].x != 4 || a_wq[a_wq.size() - 1].y != 0
            || a_wq[a_wq.size() - 1].d != 1'b1 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_resume: count=%0d last=(%0d,%0d,%0d) busy=%b, required 5 (4,0,1) 1",
                     a_wq.size(), a_wq[a_wq.size() - 1].x, a_wq[a_wq.size() - 1].y,
                     a_wq[a_wq.size() - 1].d, a_busy);
        end
    endtask

    task automatic test_random_stream();
        int k;
        logic [7:0] tok;
        a_reset();
        a_pulse_start();
        a_wq.delete();
        tq.delete();
        for (int i = 0; i < 30; i++) begin
            idle($urandom_range(0, 3));
            if (i == 15) a_pulse_start();
            tok = 8'($urandom);
            tq.push_back(tok);
            a_send(tok, k);
        end
        idle(140);
        build_model(640, 480);
        vectors++;
        if (a_wq.size() != eq.size()) begin
            miscompares++;
            $display("FAIL rand_stream_count: got %0d, required %0d", a_wq.size(), eq.size());
        end
        for (int i = 0; i < a_wq.size() && i < eq.size(); i++) begin
            vectors++;
            if (a_wq[i].x != eq[i].x || a_wq[i].y != eq[i].y || a_wq[i].d != eq[i].d) begin
                miscompares++;
                $display("FAIL rand_stream_write[%0d]: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                         i, a_wq[i].x, a_wq[i].y, a_wq[i].d, eq[i].x, eq[i].y, eq[i].d);
            end
        end
        vectors++;
        if (a_ovr !== 1'b0 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rand_stream_flags: overrun=%b busy=%b, required 0 1", a_ovr, a_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int k;
        int n = 0;
        bit hit = 1'b0;
        a_reset();
        a_pulse_start();
        a_send(8'hFF, k);
        while (!hit && n < 20) begin
            @(negedge clk);
            hit = (a_we === 1'b1 && a_x === 10'd4);
            n++;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL midrst_reach: write at x=4 not seen within 20 cycles");
        end
        a_rst_n = 1'b0;
        #1;
        vectors++;
        if ({a_we, a_x, a_y, a_d, a_busy, a_fd, a_ovr, a_ready} !== 27'd0) begin
            miscompares++;
            $display("FAIL midrst_async: got %b, required all zero",
                     {a_we, a_x, a_y, a_d, a_busy, a_fd, a_ovr, a_ready});
        end
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        a_wq.delete();
        idle(5);
        vectors++;
        if (a_wq.size() != 0 || a_ready !== 1'b0 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_idle: writes=%0d in_ready=%b busy=%b, required 0 0 0",
                     a_wq.size(), a_ready, a_busy);
        end
    endtask

    task automatic check_b_frame(input string tag);
        build_model(8, 2);
        vectors++;
        if (b_wq.size() != eq.size()) begin
            miscompares++;
            $display("FAIL %s_count: got %0d, required %0d", tag, b_wq.size(), eq.size());
        end
        for (int i = 0; i < b_wq.size() && i < eq.size(); i++) begin
            vectors++;
            if (b_wq[i].x != eq[i].x || b_wq[i].y != eq[i].y || b_wq[i].d != eq[i].d) begin
                miscompares++;
                $display("FAIL %s_write[%0d]: got (%0d,%0d,%0d), required (%0d,%0d,%0d)", tag,
                         i, b_wq[i].x, b_wq[i].y, b_wq[i].d, eq[i].x, eq[i].y, eq[i].d);
            end
        end
        vectors++;
        if (b_wq.size() == 0 || b_fd_n != 1 || b_fd_cyc != b_wq[b_wq.size() - 1].cyc + 1
            || b_fd_busy != 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: pulses=%0d at cyc %0d busy=%0d, required 1 pulse one cycle after last write, busy 0",
                     tag, b_fd_n, b_fd_cyc, b_fd_busy);
        end
    endtask

    task automatic test_full_frame();
        b_reset();
        b_pulse_start();
        b_wq.delete();
        b_fd_n = 0;
        tq.delete();
        tq.push_back(8'h87);
        tq.push_back(8'h07);
        b_send(8'h87);
        b_send(8'h07);
        b_wait_done(40);
        idle(2);
        check_b_frame("full");
        vectors++;
        if (b_ovr !== 1'b0 || b_busy !== 1'b0 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_flags: overrun=%b busy=%b in_ready=%b, required 0 0 0", b_ovr, b_busy, b_ready);
        end
    endtask

    task automatic test_overrun();
        int rdy_hi = 0;
        int n = 0;
        b_reset();
        b_pulse_start();
        b_wq.delete();
        b_fd_n = 0;
        b_send(8'h8F);
        // Upstream keeps pushing a token it cannot have accepted.
        b_data = 8'h03; b_valid = 1'b1;
        while (b_fd_n == 0 && n < 40) begin
            @(negedge clk);
            if (b_ready === 1'b1) rdy_hi++;
            @(posedge clk);
            #1;
            n++;
        end
        idle(3);
        vectors++;
        if (b_wq.size() != 16 || rdy_hi != 0 || b_ready !== 1'b0 || b_fd_n != 1) begin
            miscompares++;
            $display("FAIL ovr_frame: writes=%0d ready_cycles=%0d in_ready=%b pulses=%0d, required 16 0 0 1",
                     b_wq.size(), rdy_hi, b_ready, b_fd_n);
        end
        vectors++;
        if (b_ovr !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_flag: got %b, required 1", b_ovr);
        end
        b_valid = 1'b0;
        b_pulse_start();
        vectors++;
        if (b_ovr !== 1'b0 || b_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_clear: overrun=%b busy=%b, required 0 1", b_ovr, b_busy);
        end
        // A run that spills past the last pixel sets the flag too.
        b_wq.delete();
        b_fd_n = 0;
        tq.delete();
        tq.push_back(8'h07);
        tq.push_back(8'h8F);
        b_send(8'h07);
        b_send(8'h8F);
        b_wait_done(40);
        idle(2);
        check_b_frame("spill");
        vectors++;
        if (b_ovr !== 1'b1) begin
            miscompares++;
            $display("FAIL spill_flag: got %b, required 1", b_ovr);
        end
    endtask

    task automatic test_random_frames();
        int total;
        logic [7:0] tok;
        b_reset();
        for (int f = 0; f < 8; f++) begin
            b_pulse_start();
            b_wq.delete();
            b_fd_n = 0;
            tq.delete();
            total = 0;
            while (total < 16) begin
                if ($urandom_range(0, 4) == 0) tok = 8'($urandom);
                else tok = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 6))};
                idle($urandom_range(0, 2));
                tq.push_back(tok);
                b_send(tok);
                total += int'(tok[6:0]) + 1;
            end
            b_wait_done(200);
            idle(2);
            check_b_frame("rand_frame");
            vectors++;
            if (b_ovr !== exp_ovr) begin
                miscompares++;
                $display("FAIL rand_frame_ovr[%0d]: got %b, required %b", f, b_ovr, exp_ovr);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_run();
        test_row_wrap();
        test_back_to_back();
        test_random_stream();
        test_reset_mid_run();
        test_full_frame();
        test_overrun();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
